intersection_scheduler: RTL and testbench
=========================================

# intersection_scheduler

Two-approach intersection scheduler sharing the right-of-way between the north-south (NS) and east-west (EW) roads and a pedestrian walk phase. It consumes the 1 s tick produced by `counter_pulse` and sequences green, yellow, all-red and walk phases with min/max green and demand-driven gap-out. It replaces per-road standalone light FSMs at the top level and drives all lamp outputs directly.

## Interface
- `GREEN_MIN`, 5: ticks a green must hold before demand can end it
- `GREEN_MAX`, 20: ticks after which a green ends if any conflicting demand exists
- `YELLOW_TIME`, 3: ticks in each yellow
- `ALL_RED_TIME`, 1: ticks in each all-red clearance
- `WALK_TIME`, 8: ticks in the walk phase
- `TW`, 5: timer width; must hold max(all times)
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `tick_1s` in 1: one-cycle timebase pulse
- `car_ns` in 1: NS vehicle sensor (level)
- `car_ew` in 1: EW vehicle sensor (level)
- `ped_req` in 1: pedestrian button (pulse or level)
- `ns_red`, `ns_yellow`, `ns_green` out 1: NS lamps
- `ew_red`, `ew_yellow`, `ew_green` out 1: EW lamps
- `walk` out 1: pedestrian walk lamp
- `ped_pending` out 1: latched pedestrian request
- `phase` out 3: current state code
- `timer_clr` out 1: one-cycle pulse on every state entry (resets external `counter_pulse`)

## Operation
- States: `CLR_TO_NS` (0), `NS_GREEN` (1), `NS_YELLOW` (2), `CLR_TO_EW` (3), `EW_GREEN` (4), `EW_YELLOW` (5), `PED_WALK` (6).
- Timer: cleared on state entry; increments on `tick_1s`, saturating at 2^TW-1. A state with duration N exits on the clock edge where `tick_1s`=1 and timer==N-1.
- `NS_GREEN`: exit to `NS_YELLOW` when timer≥GREEN_MIN-1 on a tick and (`car_ew` or `ped_pending`), or at timer≥GREEN_MAX-1 under the same demand condition. With no conflicting demand, rest in green indefinitely.
- `EW_GREEN`: symmetric; demand is `car_ns` or `ped_pending`.
- Yellow: YELLOW_TIME ticks, then to the clearance state of the opposite road.
- `CLR_TO_x`: ALL_RED_TIME ticks. If `ped_pending`, go to `PED_WALK`; else go to `x_GREEN`.
- `PED_WALK`: WALK_TIME ticks, then to the same `CLR_TO_x` it came from, re-entered with `ped_pending` now 0, so the next state is `x_GREEN`. A register records the pending target road.
- `ped_pending`: set by `ped_req`; cleared on entry to `PED_WALK`. If `ped_req` is high in the entry cycle, the request is treated as served and stays cleared.
- Lamps are decoded from the state register:
  - NS lamps: green only in `NS_GREEN`, yellow only in `NS_YELLOW`, red otherwise.
  - EW lamps: same rule for the EW states.
  - `walk`=1 only in `PED_WALK`.
  - Exactly one lamp per road is lit at all times.

## Timing
- Reset values:
  - State `CLR_TO_NS`, timer 0.
  - `ns_red`=`ew_red`=1; all other lamps 0; `walk`=0.
  - `ped_pending`=0, `phase`=0, `timer_clr`=1 during reset.
- State changes take effect on the edge where the exit condition holds. Lamps and `phase` change in the same cycle the new state is visible.
- `timer_clr` is high in the first cycle of each new state.
- `tick_1s` is ignored in the cycle `timer_clr` is high, which prevents a double count across a boundary.
- `rst` mid-phase returns to the reset state on the next edge, regardless of tick or requests.
- `tick_1s` held high for multiple cycles counts once per cycle. This is legal but not expected.

## Configuration
- `INTERSECTION_PED_EN` defined:
  - Pedestrian logic present as described.
- Not defined:
  - `ped_req` ignored; `ped_pending` and `walk` tied 0.
  - `PED_WALK` is unreachable.
  - Green exit demand is the opposing car sensor only.

## Structure
- Package `intersection_pkg`:
  - State encodings and `phase` codes.
  - Default durations.
  - `TW` derivation helper.
- Sub-module `phase_timer`:
  - Inputs: `clk`, `rst`, `clr`, `tick`.
  - Outputs: saturating count and `done` for a given limit.
  - One instance.

## Test plan
Common parameters: GREEN_MIN=2, GREEN_MAX=4, YELLOW_TIME=1, ALL_RED_TIME=1, WALK_TIME=2; tick every 4 cycles.
- Reset release, no demand:
  - `CLR_TO_NS` for 1 tick, then `NS_GREEN`.
  - Stays `NS_GREEN` for 20 ticks with `ns_green`=1, `ew_red`=1.
- `car_ew`=1 from reset:
  - `NS_GREEN` lasts exactly 2 ticks, then `NS_YELLOW` 1 tick, `CLR_TO_EW` 1 tick, `EW_GREEN`.
- `car_ew`=1 asserted at NS green tick 3:
  - Exit on that tick's edge (≥GREEN_MIN).
  - Both sensors high: alternates NS/EW, each green exactly 2 ticks.
- Pulse `ped_req` during `NS_GREEN`:
  - `ped_pending`=1.
  - Sequence: `NS_YELLOW` → `CLR_TO_EW` → `PED_WALK` with `walk`=1 for 2 ticks → `CLR_TO_EW` → `EW_GREEN`.
  - `ped_pending`=0 from walk entry.
- `ped_req` held high across `PED_WALK` entry:
  - `ped_pending` stays 0 after entry.
  - No second walk.
- `rst` asserted mid-`EW_YELLOW`:
  - Next edge: `phase`=0, both reds 1, timer 0.
  - Without `INTERSECTION_PED_EN`, `ped_req` pulses never raise `walk` or `ped_pending`.

Source files
------------

// File: rtl/intersection_pkg.sv
// Shared state encodings, default phase durations and timer sizing helpers
// for the intersection scheduler.
package intersection_pkg;

  typedef enum logic [2:0] {
    CLR_TO_NS = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    CLR_TO_EW = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    PED_WALK  = 3'd6
  } state_t;

  localparam int DEF_GREEN_MIN    = 5;
  localparam int DEF_GREEN_MAX    = 20;
  localparam int DEF_YELLOW_TIME  = 3;
  localparam int DEF_ALL_RED_TIME = 1;
  localparam int DEF_WALK_TIME    = 8;

  function automatic int max_time(input int a, input int b, input int c,
                                  input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

  // Bits needed so the timer can hold the longest duration without wrapping.
  function automatic int timer_width(input int longest);
    return (longest < 2) ? 1 : $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// Per-phase tick counter: cleared on state entry, saturating on tick_1s,
// flags the tick that completes the current phase duration.
module phase_timer #(
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          tick,
  input  logic [TW-1:0] limit,
  output logic [TW-1:0] count,
  output logic          done
);

  // A tick landing in the clear cycle is dropped so a boundary never counts twice.
  assign done = tick & ~clr & (count == (limit - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (tick && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/intersection_scheduler.sv
// Two-road intersection scheduler with green/yellow/all-red sequencing and
// gap-out; pedestrian walk phase present only when INTERSECTION_PED_EN is defined.
module intersection_scheduler
  import intersection_pkg::*;
#(
  parameter int GREEN_MIN    = DEF_GREEN_MIN,
  parameter int GREEN_MAX    = DEF_GREEN_MAX,
  parameter int YELLOW_TIME  = DEF_YELLOW_TIME,
  parameter int ALL_RED_TIME = DEF_ALL_RED_TIME,
  parameter int WALK_TIME    = DEF_WALK_TIME,
  parameter int TW           = timer_width(max_time(GREEN_MIN, GREEN_MAX, YELLOW_TIME,
                                                    ALL_RED_TIME, WALK_TIME))
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_req,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase,
  output logic       timer_clr
);

  state_t        state, state_next;
  logic [TW-1:0] count, limit;
  logic          done, tick_ok, ped_demand, ped_target;
  logic          ns_exit, ew_exit, past_min;

  phase_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .tick  (tick_1s),
    .limit (limit),
    .count (count),
    .done  (done)
  );

`ifdef INTERSECTION_PED_EN
  assign ped_demand = ped_pending;
`else
  logic unused_ped;
  assign ped_demand = 1'b0;
  assign unused_ped = ped_req;
`endif

  assign tick_ok  = tick_1s & ~timer_clr;
  assign past_min = (count >= TW'(GREEN_MIN - 1)) | (count >= TW'(GREEN_MAX - 1));
  assign ns_exit  = tick_ok & past_min & (car_ew | ped_demand);
  assign ew_exit  = tick_ok & past_min & (car_ns | ped_demand);

  always_comb begin
    limit = TW'(ALL_RED_TIME);
    case (state)
      NS_YELLOW, EW_YELLOW: limit = TW'(YELLOW_TIME);
      PED_WALK:             limit = TW'(WALK_TIME);
      default:              limit = TW'(ALL_RED_TIME);
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      CLR_TO_NS: if (done) state_next = ped_demand ? PED_WALK : NS_GREEN;
      NS_GREEN:  if (ns_exit) state_next = NS_YELLOW;
      NS_YELLOW: if (done) state_next = CLR_TO_EW;
      CLR_TO_EW: if (done) state_next = ped_demand ? PED_WALK : EW_GREEN;
      EW_GREEN:  if (ew_exit) state_next = EW_YELLOW;
      EW_YELLOW: if (done) state_next = CLR_TO_NS;
      // Walk returns to the clearance it interrupted, which then grants that road.
      PED_WALK:  if (done) state_next = ped_target ? CLR_TO_EW : CLR_TO_NS;
      default:   state_next = CLR_TO_NS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLR_TO_NS;
      phase       <= 3'd0;
      timer_clr   <= 1'b1;
      ns_red      <= 1'b1;
      ns_yellow   <= 1'b0;
      ns_green    <= 1'b0;
      ew_red      <= 1'b1;
      ew_yellow   <= 1'b0;
      ew_green    <= 1'b0;
      walk        <= 1'b0;
      ped_pending <= 1'b0;
      ped_target  <= 1'b0;
    end else begin
      state     <= state_next;
      phase     <= state_next;
      timer_clr <= (state_next != state);
      ns_green  <= (state_next == NS_GREEN);
      ns_yellow <= (state_next == NS_YELLOW);
      ns_red    <= (state_next != NS_GREEN) && (state_next != NS_YELLOW);
      ew_green  <= (state_next == EW_GREEN);
      ew_yellow <= (state_next == EW_YELLOW);
      ew_red    <= (state_next != EW_GREEN) && (state_next != EW_YELLOW);
`ifdef INTERSECTION_PED_EN
      walk <= (state_next == PED_WALK);
      // Entering the walk serves the request, even if the button is still held.
      if ((state_next == PED_WALK) && (state != PED_WALK)) begin
        ped_pending <= 1'b0;
        ped_target  <= (state == CLR_TO_EW);
      end else if (ped_req && (state != PED_WALK)) begin
        ped_pending <= 1'b1;
      end
`else
      walk        <= 1'b0;
      ped_pending <= 1'b0;
      ped_target  <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Randomized scoreboard bench for intersection_scheduler against a phase/tick
// reference model; follows INTERSECTION_PED_EN to decide pedestrian behaviour.
module tb_intersection_scheduler;

  localparam int GMIN = 2;
  localparam int GMAX = 4;
  localparam int YT   = 1;
  localparam int ART  = 1;
  localparam int WT   = 2;
`ifdef INTERSECTION_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, tick_1s, car_ns, car_ew, ped_req;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic       walk, ped_pending, timer_clr;
  logic [2:0] phase;

  typedef struct {
    int         cyc;
    logic [2:0] phase;
    logic [6:0] lamps;
    logic       pend;
    logic       clr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_push = 0;
  int   cyc_mon = 0;

  // Reference model: named phase, ticks counted in it, first-cycle flag.
  int m_phase = 0;
  int m_ticks = 0;
  bit m_first = 1'b1;
  bit m_pend = 1'b0;
  int m_from = 0;

  intersection_scheduler #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_TIME(YT),
    .ALL_RED_TIME(ART), .WALK_TIME(WT), .TW(5)
  ) u_dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .car_ns(car_ns), .car_ew(car_ew),
    .ped_req(ped_req), .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green), .walk(walk),
    .ped_pending(ped_pending), .phase(phase), .timer_clr(timer_clr)
  );

  always #5 clk = ~clk;

  // Lamp vector {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk} for a phase number.
  function automatic logic [6:0] lamps_of(input int ph);
    logic [2:0] ns, ew;
    ns = (ph == 1) ? 3'b001 : (ph == 2) ? 3'b010 : 3'b100;
    ew = (ph == 4) ? 3'b001 : (ph == 5) ? 3'b010 : 3'b100;
    return {ns, ew, (ph == 6)};
  endfunction

  task automatic model_step(input bit r, input bit t, input bit cn, input bit ce, input bit p);
    int  nxt;
    bit  counted;
    if (r) begin
      m_phase = 0; m_ticks = 0; m_first = 1'b1; m_pend = 1'b0; m_from = 0;
      return;
    end
    counted = t && !m_first;
    nxt = m_phase;
    case (m_phase)
      0: if (counted && m_ticks == ART - 1) nxt = m_pend ? 6 : 1;
      3: if (counted && m_ticks == ART - 1) nxt = m_pend ? 6 : 4;
      1: if (counted && (ce || m_pend) && m_ticks >= GMIN - 1) nxt = 2;
      4: if (counted && (cn || m_pend) && m_ticks >= GMIN - 1) nxt = 5;
      2: if (counted && m_ticks == YT - 1) nxt = 3;
      5: if (counted && m_ticks == YT - 1) nxt = 0;
      6: if (counted && m_ticks == WT - 1) nxt = m_from;
      default: nxt = 0;
    endcase
    if (nxt == 6 && m_phase != 6) begin
      m_pend = 1'b0;
      m_from = m_phase;
    end else if (PED_EN && p && m_phase != 6) begin
      m_pend = 1'b1;
    end
    if (nxt != m_phase) begin
      m_ticks = 0;
      m_first = 1'b1;
    end else begin
      m_first = 1'b0;
      if (counted && m_ticks < 31) m_ticks++;
    end
    m_phase = nxt;
  endtask

  task automatic applyStimulus(input bit r, input bit t, input bit cn, input bit ce, input bit p);
    exp_t e;
    rst = r; tick_1s = t; car_ns = cn; car_ew = ce; ped_req = p;
    model_step(r, t, cn, ce, p);
    cyc_push++;
    e.cyc = cyc_push;
    e.phase = 3'(m_phase);
    e.lamps = lamps_of(m_phase);
    e.pend = m_pend;
    e.clr = m_first;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc_mon, act, req);
    end
  endtask

  // Monitor: one DUT output sample per cycle, popped against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #4;
      cyc_mon++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard empty at cycle %0d", cyc_mon);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc_mon) begin
          errors++;
          $display("[TB] FAIL alignment: got cycle %0d, expected %0d", cyc_mon, e.cyc);
        end
        checkOutput("phase", int'(phase), int'(e.phase));
        checkOutput("lamps", int'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}),
                    int'(e.lamps));
        checkOutput("ped_pending", int'(ped_pending), int'(e.pend));
        checkOutput("timer_clr", int'(timer_clr), int'(e.clr));
      end
    end
  end

  initial begin
    bit p, cn, ce, t, r;
    int seen;
    $display("[TB] start, PED_EN=%0d", PED_EN);
    repeat (3) applyStimulus(1, 0, 0, 0, 0);
    for (int k = 0; k < 100; k++) applyStimulus(0, (k % 4) == 3, 0, 0, 0);
    for (int k = 0; k < 60; k++) applyStimulus(0, (k % 4) == 3, 0, 1, 0);
    for (int k = 0; k < 200; k++) begin
      cn = ($urandom_range(0, 3) != 0);
      ce = ($urandom_range(0, 3) != 0);
      applyStimulus(0, (k % 4) == 3, cn, ce, 0);
    end
    for (int k = 0; k < 240; k++) begin
      p  = ($urandom_range(0, 29) == 0);
      cn = ($urandom_range(0, 7) == 0);
      ce = ($urandom_range(0, 7) == 0);
      applyStimulus(0, (k % 4) == 3, cn, ce, p);
    end
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      if (m_phase == 6) seen++;
      p = (seen < 3);
      applyStimulus(0, (k % 4) == 3, 0, 1, p);
    end
    for (int k = 0; k < 60; k++) applyStimulus(0, (k % 4) == 3, 1, 1, 0);
    for (int k = 0; k < 300; k++) begin
      if (m_phase == 5) break;
      applyStimulus(0, (k % 4) == 3, 1, 1, 0);
    end
    applyStimulus(1, 1, 1, 1, 1);
    for (int k = 0; k < 40; k++) applyStimulus(0, (k % 4) == 3, 0, 0, (k % 5) == 0);
    for (int k = 0; k < 600; k++) begin
      r  = ($urandom_range(0, 149) == 0);
      t  = ($urandom_range(0, 3) == 0);
      cn = $urandom_range(0, 1) == 1;
      ce = $urandom_range(0, 1) == 1;
      p  = ($urandom_range(0, 19) == 0);
      applyStimulus(r, t, cn, ce, p);
    end
    #5;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
